axis_fifo_tx: RTL and testbench

Read-side stream transmitter for the clock-crossing packet FIFO. It pops first-word-fall-through FIFO words packed as {tlast, tkeep, tdata} and drives an AXI-Stream master port with full ready/valid handshaking through a 2-entry output buffer. It enforces a maximum packet length by truncating oversized packets, and keeps packet and truncation counters. It sits in the tx_clk domain between the FIFO read port and the downstream tx_axis consumer.

---
 rtl/axis_fifo_tx.sv | 89 ++++++++
 tb/tb_axis_fifo_tx.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/axis_fifo_tx.sv
// axis_fifo_tx: FWFT FIFO to AXI-Stream master with a 2-entry skid buffer,
// max-length truncation, and packet/truncation counters.
module axis_fifo_tx #(
  parameter int DSIZE     = 32,
  parameter int KSIZE     = 4,
  parameter int MAX_BEATS = 256
) (
  input  logic                   tx_clk,
  input  logic                   tx_rst_n,
  input  logic [DSIZE+KSIZE:0]   fifo_rdata,
  input  logic                   fifo_rempty,
  output logic                   fifo_rinc,
  input  logic                   tx_axis_tready,
  output logic                   tx_axis_tvalid,
  output logic [DSIZE-1:0]       tx_axis_tdata,
  output logic [KSIZE-1:0]       tx_axis_tkeep,
  output logic                   tx_axis_tlast,
  output logic                   trunc_err,
  output logic [31:0]            pkt_count,
  output logic [15:0]            trunc_count
);
  localparam int W  = DSIZE + KSIZE + 1;
  localparam int BW = $clog2(MAX_BEATS + 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, DISCARD} state_t;

  state_t        state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [BW-1:0] bcnt_q, bcnt_d, bnext;
  logic [W-1:0]  head_q, head_d, skid_q, skid_d, word;
  logic [31:0]   pkt_q, pkt_d;
  logic [15:0]   trc_q, trc_d;
  logic          terr_q, terr_d;
  logic          last_in, trunc, push, xfer;

  // Pop is gated by reset so nothing is consumed while the block is held.
  assign fifo_rinc = tx_rst_n && !fifo_rempty && (state_q == DISCARD || cnt_q < 2'd2);
  assign last_in   = fifo_rdata[W-1];
  assign bnext     = (state_q == IDLE) ? BW'(1) : bcnt_q + BW'(1);
  assign trunc     = fifo_rinc && state_q == ACTIVE && !last_in && bnext == BW'(MAX_BEATS);
  assign push      = fifo_rinc && state_q != DISCARD;
  assign word      = {last_in | trunc, fifo_rdata[W-2:0]};
  assign xfer      = cnt_q != 2'd0 && tx_axis_tready;

  always_comb begin
    state_d = !fifo_rinc ? state_q :
              state_q == DISCARD ? (last_in ? IDLE : DISCARD) :
              trunc ? DISCARD : last_in ? IDLE : ACTIVE;
    bcnt_d  = push ? bnext : bcnt_q;
    cnt_d   = cnt_q + {1'b0, push} - {1'b0, xfer};
    // A new word lands in head when head is (or becomes) free, else in skid.
    head_d  = (cnt_q == 2'd0 || (cnt_q == 2'd1 && xfer)) ? (push ? word : head_q) :
              (cnt_q == 2'd2 && xfer) ? skid_q : head_q;
    skid_d  = (cnt_q == 2'd1 && push && !xfer) ? word : skid_q;
    pkt_d   = pkt_q + 32'(xfer && head_q[W-1]);
    trc_d   = trc_q + 16'(trunc && trc_q != 16'hFFFF);
    terr_d  = trunc;
  end

  always_ff @(posedge tx_clk or negedge tx_rst_n) begin
    if (!tx_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bcnt_q  <= '0;
      head_q  <= '0;
      skid_q  <= '0;
      pkt_q   <= '0;
      trc_q   <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bcnt_q  <= bcnt_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
      pkt_q   <= pkt_d;
      trc_q   <= trc_d;
      terr_q  <= terr_d;
    end
  end

  assign tx_axis_tvalid = cnt_q != 2'd0;
  assign tx_axis_tlast  = head_q[W-1];
  assign tx_axis_tkeep  = head_q[DSIZE +: KSIZE];
  assign tx_axis_tdata  = head_q[DSIZE-1:0];
  assign trunc_err      = terr_q;
  assign pkt_count      = pkt_q;
  assign trunc_count    = trc_q;
endmodule

// File: tb/tb_axis_fifo_tx.sv
// tb_axis_fifo_tx: two instances (MAX_BEATS 256 and 4) fed from queue FIFOs,
// checked against per-packet expected beat lists built from the length rules.
module tb_axis_fifo_tx;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [36:0] rdata [2];
  logic        rempty[2];
  logic        rinc  [2];
  logic        tready[2];
  logic        tvalid[2];
  logic [31:0] tdata [2];
  logic [3:0]  tkeep [2];
  logic        tlast [2];
  logic        terr  [2];
  logic [31:0] pcnt  [2];
  logic [15:0] tcnt  [2];

  axis_fifo_tx #(.DSIZE(32), .KSIZE(4), .MAX_BEATS(256)) dut_a (
    .tx_clk(clk), .tx_rst_n(rst_n), .fifo_rdata(rdata[0]), .fifo_rempty(rempty[0]),
    .fifo_rinc(rinc[0]), .tx_axis_tready(tready[0]), .tx_axis_tvalid(tvalid[0]),
    .tx_axis_tdata(tdata[0]), .tx_axis_tkeep(tkeep[0]), .tx_axis_tlast(tlast[0]),
    .trunc_err(terr[0]), .pkt_count(pcnt[0]), .trunc_count(tcnt[0]));

  axis_fifo_tx #(.DSIZE(32), .KSIZE(4), .MAX_BEATS(4)) dut_b (
    .tx_clk(clk), .tx_rst_n(rst_n), .fifo_rdata(rdata[1]), .fifo_rempty(rempty[1]),
    .fifo_rinc(rinc[1]), .tx_axis_tready(tready[1]), .tx_axis_tvalid(tvalid[1]),
    .tx_axis_tdata(tdata[1]), .tx_axis_tkeep(tkeep[1]), .tx_axis_tlast(tlast[1]),
    .trunc_err(terr[1]), .pkt_count(pcnt[1]), .trunc_count(tcnt[1]));

  always #5 clk = ~clk;

  logic [36:0] fq[2][$];
  bit          fk[2][$];
  logic [36:0] eq[2][$];
  int          inflight[2];
  bit          held[2];
  logic [36:0] hold[2];
  logic [31:0] epkt[2];
  logic [15:0] etc[2];
  int          ntr[2], nterr[2];
  int          checks = 0, errors = 0;
  int          cyc = 0, mode = 0, nx0 = 0, first0 = 0, last0 = 0;
  bit          stall = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic upd(int i);
    rempty[i] = fq[i].size() == 0 || (stall && $urandom_range(3) == 0);
    rdata[i]  = fq[i].size() != 0 ? fq[i][0] : '0;
    tready[i] = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 3 == 0) : 1'($urandom_range(1));
  endtask

  task automatic send_pkt(int i, int len, logic [31:0] base, logic [3:0] keep, bit rnd);
    int mb;
    logic [31:0] d;
    logic [3:0] kp;
    mb = i ? 4 : 256;
    for (int k = 1; k <= len; k++) begin
      d  = rnd ? $urandom : base + 32'(k - 1);
      kp = rnd ? 4'($urandom) : keep;
      fq[i].push_back({k == len, kp, d});
      fk[i].push_back(k <= mb);
      if (k <= mb) eq[i].push_back({k == len || k == mb, kp, d});
    end
    epkt[i]++;
    if (len > mb) begin
      ntr[i]++;
      etc[i] = etc[i] == 16'hFFFF ? etc[i] : etc[i] + 16'd1;
    end
    upd(i);
  endtask

  task automatic tick();
    bit dp[2], dx[2];
    logic [36:0] b;
    #1;
    for (int i = 0; i < 2; i++) begin
      b = {tlast[i], tkeep[i], tdata[i]};
      dp[i] = rinc[i];
      dx[i] = tvalid[i] && tready[i];
      chk("tvalid", 64'(tvalid[i]), 64'(inflight[i] != 0));
      chk("buffer_bound", 64'(inflight[i] <= 2), 64'd1);
      if (held[i]) chk("stall_stable", 64'(b), 64'(hold[i]));
      held[i] = tvalid[i] && !tready[i];
      hold[i] = b;
      if (terr[i]) nterr[i]++;
      if (dx[i]) begin
        chk("beat_avail", 64'(eq[i].size() != 0), 64'd1);
        if (eq[i].size() != 0) chk("beat", 64'(b), 64'(eq[i].pop_front()));
        if (i == 0) begin
          if (nx0 == 0) first0 = cyc;
          last0 = cyc;
          nx0++;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (dp[i] && fq[i].size() != 0) begin
        if (fk[i].pop_front()) inflight[i]++;
        void'(fq[i].pop_front());
      end
      if (dx[i]) inflight[i]--;
      upd(i);
    end
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while ((fq[0].size() + fq[1].size() + eq[0].size() + eq[1].size()) != 0 && n < 3000) begin
      tick();
      n++;
    end
    tick();
    tick();
    chk("drained", 64'(fq[0].size() + fq[1].size() + eq[0].size() + eq[1].size()), 64'd0);
  endtask

  task automatic cnts(int i);
    chk("pkt_count", 64'(pcnt[i]), 64'(epkt[i]));
    chk("trunc_count", 64'(tcnt[i]), 64'(etc[i]));
    chk("trunc_pulses", 64'(nterr[i]), 64'(ntr[i]));
  endtask

  task automatic rst_chk();
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_tvalid", 64'(tvalid[i]), 64'd0);
      chk("rst_beat", 64'({tlast[i], tkeep[i], tdata[i]}), 64'd0);
      chk("rst_rinc", 64'(rinc[i]), 64'd0);
      chk("rst_terr", 64'(terr[i]), 64'd0);
      chk("rst_counts", 64'({pcnt[i], tcnt[i]}), 64'd0);
      fq[i].delete();
      fk[i].delete();
      eq[i].delete();
      inflight[i] = 0;
      held[i] = 0;
      epkt[i] = 0;
      etc[i] = 0;
      ntr[i] = 0;
      nterr[i] = 0;
      upd(i);
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) upd(i);
    rst_chk();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    // Interrupt a packet that is mid-flight under backpressure.
    mode = 1;
    send_pkt(0, 8, 32'd50, 4'hF, 0);
    send_pkt(1, 6, 32'd70, 4'hF, 0);
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    mode = 0;
    rst_chk();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    send_pkt(0, 1, 32'hA5A5A5A5, 4'hF, 0);
    #1;
    chk("first_pop", 64'(rinc[0]), 64'd1);
    tick();
    chk("latency_valid", 64'(tvalid[0]), 64'd1);
    chk("latency_data", 64'({tlast[0], tkeep[0], tdata[0]}), {27'd0, 1'b1, 4'hF, 32'hA5A5A5A5});
    drain();
    nx0 = 0;
    send_pkt(0, 10, 32'd1, 4'hF, 0);
    drain();
    chk("stream_span", 64'(last0 - first0), 64'd9);
    chk("stream_beats", 64'(nx0), 64'd10);
    cnts(0);
    mode = 1;
    send_pkt(0, 20, 32'd100, 4'hA, 0);
    drain();
    cnts(0);
    mode = 0;
    send_pkt(1, 7, 32'd1, 4'hF, 0);
    send_pkt(1, 2, 32'd8, 4'hF, 0);
    drain();
    cnts(1);
    send_pkt(1, 4, 32'd20, 4'hF, 0);
    send_pkt(1, 1, 32'd30, 4'h0, 0);
    drain();
    cnts(1);
    mode = 2;
    stall = 1;
    for (int p = 0; p < 40; p++) begin
      send_pkt(p % 2, $urandom_range(9, 1), 32'd0, 4'h0, 1);
      repeat ($urandom_range(4)) tick();
    end
    drain();
    cnts(0);
    cnts(1);
    mode = 0;
    stall = 0;
    force dut_a.pkt_q = 32'hFFFF_FFFF;
    force dut_b.trc_q = 16'hFFFF;
    tick();
    tick();
    release dut_a.pkt_q;
    release dut_b.trc_q;
    tick();
    epkt[0] = 32'hFFFF_FFFF;
    etc[1] = 16'hFFFF;
    cnts(0);
    cnts(1);
    send_pkt(0, 1, 32'd77, 4'h3, 0);
    send_pkt(1, 6, 32'd88, 4'hC, 0);
    drain();
    chk("pkt_wrap", 64'(pcnt[0]), 64'd0);
    cnts(0);
    cnts(1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
